// File: rtl/lcd_show_char.sv
// lcd_show_char: renders one font glyph to the LCD over a byte-write port.
// Ports: sys_clk/sys_rst_n; request (show_char_flag, ascii_num, start_x,
//   start_y, en_size); status (show_char_done, busy); font ROM (rom_addr,
//   rom_data); byte writer (wr_req, wr_data[8]=D/C, wr_done).
module lcd_show_char #(
   parameter logic [15:0] FG_COLOR    = 16'h0000,
   parameter logic [15:0] BG_COLOR    = 16'hFFFF,
   parameter logic [11:0] ROM_BASE_16 = 12'd0,
   parameter logic [11:0] ROM_BASE_12 = 12'd1520,
   parameter int          HOLDOFF     = 3
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        show_char_flag,
   input  logic [6:0]  ascii_num,
   input  logic [8:0]  start_x,
   input  logic [8:0]  start_y,
   input  logic        en_size,
   output logic        show_char_done,
   output logic        busy,
   output logic [11:0] rom_addr,
   input  logic [7:0]  rom_data,
   output logic        wr_req,
   output logic [8:0]  wr_data,
   input  logic        wr_done
);

   typedef enum logic [3:0] {
      S_IDLE, S_CMD, S_FETCH, S_WAIT, S_LATCH,
      S_PIX_H, S_PIX_L, S_DONE, S_HOLD
   } state_t;

   localparam logic [7:0] HOLD_LAST =
      8'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

   state_t      state_q, state_d;
   logic [6:0]  idx_q, idx_d;
   logic [8:0]  x_q, x_d;
   logic [8:0]  y_q, y_d;
   logic        size_q, size_d;
   logic [3:0]  cmd_cnt_q, cmd_cnt_d;
   logic [3:0]  row_q, row_d;
   logic [2:0]  col_q, col_d;
   logic [7:0]  shift_q, shift_d;
   logic        pend_q, pend_d;
   logic [7:0]  hold_cnt_q, hold_cnt_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;
   logic [11:0] rom_addr_q, rom_addr_d;
   logic        wr_req_q, wr_req_d;
   logic [8:0]  wr_data_q, wr_data_d;

   logic [8:0]  w_m1, h_m1, xe, ye;
   logic [2:0]  col_last;
   logic [3:0]  row_last;
   logic [11:0] glyph_off, base, fetch_addr;
   logic [15:0] pix_color;
   logic [8:0]  cmd_byte;
   logic        wr_ack;

   assign w_m1     = size_q ? 9'd7 : 9'd5;
   assign h_m1     = size_q ? 9'd15 : 9'd11;
   assign xe       = x_q + w_m1;
   assign ye       = y_q + h_m1;
   assign col_last = size_q ? 3'd7 : 3'd5;
   assign row_last = size_q ? 4'd15 : 4'd11;
   assign base     = size_q ? ROM_BASE_16 : ROM_BASE_12;

   // idx*16 for the large font, idx*12 as (idx<<3)+(idx<<2) for the small one
   assign glyph_off = size_q ? {1'b0, idx_q, 4'b0}
                             : ({2'b0, idx_q, 3'b0} + {3'b0, idx_q, 2'b0});
   assign fetch_addr = base + glyph_off + {8'b0, row_q};
   assign pix_color  = shift_q[7] ? FG_COLOR : BG_COLOR;

   // a pending byte completes only on wr_done; stray pulses are ignored
   assign wr_ack = pend_q & wr_done;

   always_comb begin
      cmd_byte = 9'h000;
      case (cmd_cnt_q)
         4'd0:    cmd_byte = 9'h02A;
         4'd1:    cmd_byte = {1'b1, 7'b0, x_q[8]};
         4'd2:    cmd_byte = {1'b1, x_q[7:0]};
         4'd3:    cmd_byte = {1'b1, 7'b0, xe[8]};
         4'd4:    cmd_byte = {1'b1, xe[7:0]};
         4'd5:    cmd_byte = 9'h02B;
         4'd6:    cmd_byte = {1'b1, 7'b0, y_q[8]};
         4'd7:    cmd_byte = {1'b1, y_q[7:0]};
         4'd8:    cmd_byte = {1'b1, 7'b0, ye[8]};
         4'd9:    cmd_byte = {1'b1, ye[7:0]};
         4'd10:   cmd_byte = 9'h02C;
         default: cmd_byte = 9'h000;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      x_d        = x_q;
      y_d        = y_q;
      size_d     = size_q;
      cmd_cnt_d  = cmd_cnt_q;
      row_d      = row_q;
      col_d      = col_q;
      shift_d    = shift_q;
      pend_d     = pend_q;
      hold_cnt_d = hold_cnt_q;
      done_d     = 1'b0;
      busy_d     = busy_q;
      rom_addr_d = rom_addr_q;
      wr_req_d   = 1'b0;
      wr_data_d  = wr_data_q;
      case (state_q)
         S_IDLE: begin
            if (show_char_flag) begin
               idx_d     = (ascii_num > 7'd94) ? 7'd0 : ascii_num;
               x_d       = start_x;
               y_d       = start_y;
               size_d    = en_size;
               cmd_cnt_d = 4'd0;
               row_d     = 4'd0;
               col_d     = 3'd0;
               busy_d    = 1'b1;
               state_d   = S_CMD;
            end
         end
         S_CMD: begin
            if (!pend_q) begin
               wr_req_d  = 1'b1;
               wr_data_d = cmd_byte;
               pend_d    = 1'b1;
            end else if (wr_ack) begin
               pend_d = 1'b0;
               if (cmd_cnt_q == 4'd10) begin
                  state_d = S_FETCH;
               end else begin
                  cmd_cnt_d = cmd_cnt_q + 4'd1;
               end
            end
         end
         S_FETCH: begin
            rom_addr_d = fetch_addr;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            state_d = S_LATCH;
         end
         S_LATCH: begin
            shift_d = rom_data;
            col_d   = 3'd0;
            state_d = S_PIX_H;
         end
         S_PIX_H: begin
            if (!pend_q) begin
               wr_req_d  = 1'b1;
               wr_data_d = {1'b1, pix_color[15:8]};
               pend_d    = 1'b1;
            end else if (wr_ack) begin
               pend_d  = 1'b0;
               state_d = S_PIX_L;
            end
         end
         S_PIX_L: begin
            if (!pend_q) begin
               wr_req_d  = 1'b1;
               wr_data_d = {1'b1, pix_color[7:0]};
               pend_d    = 1'b1;
            end else if (wr_ack) begin
               pend_d = 1'b0;
               if (col_q == col_last) begin
                  col_d = 3'd0;
                  if (row_q == row_last) begin
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     row_d   = row_q + 4'd1;
                     state_d = S_FETCH;
                  end
               end else begin
                  col_d   = col_q + 3'd1;
                  shift_d = {shift_q[6:0], 1'b0};
                  state_d = S_PIX_H;
               end
            end
         end
         S_DONE: begin
            hold_cnt_d = 8'd0;
            if (HOLDOFF == 0) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (hold_cnt_q == HOLD_LAST) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         x_q        <= '0;
         y_q        <= '0;
         size_q     <= 1'b0;
         cmd_cnt_q  <= '0;
         row_q      <= '0;
         col_q      <= '0;
         shift_q    <= '0;
         pend_q     <= 1'b0;
         hold_cnt_q <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         rom_addr_q <= '0;
         wr_req_q   <= 1'b0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         x_q        <= x_d;
         y_q        <= y_d;
         size_q     <= size_d;
         cmd_cnt_q  <= cmd_cnt_d;
         row_q      <= row_d;
         col_q      <= col_d;
         shift_q    <= shift_d;
         pend_q     <= pend_d;
         hold_cnt_q <= hold_cnt_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         rom_addr_q <= rom_addr_d;
         wr_req_q   <= wr_req_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign show_char_done = done_q;
   assign busy           = busy_q;
   assign rom_addr       = rom_addr_q;
   assign wr_req         = wr_req_q;
   assign wr_data        = wr_data_q;

endmodule

// File: tb/tb_lcd_show_char.sv
// tb_lcd_show_char: directed bench for lcd_show_char with a byte-writer
// model, a combinational font ROM model and a reference stream builder.
module tb_lcd_show_char;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        show_char_flag;
   logic [6:0]  ascii_num;
   logic [8:0]  start_x;
   logic [8:0]  start_y;
   logic        en_size;
   logic        show_char_done;
   logic        busy;
   logic [11:0] rom_addr;
   logic [7:0]  rom_data;
   logic        wr_req;
   logic [8:0]  wr_data;
   logic        wr_done;
   logic        wr_done_w = 1'b0;
   logic        wr_done_s = 1'b0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_cnt = 0;
   int rise_cnt = 0;
   int last_done_cyc = 0;
   int last_rise_cyc = 0;
   bit prev_busy = 1'b0;
   int wr_cnt = 0;
   int hs_viol = 0;
   bit rand_lat = 1'b0;
   int rmin = 4095;
   int rmax = 0;
   logic [8:0] got[$];
   logic [8:0] exp_q[$];

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   assign wr_done = wr_done_w | wr_done_s;

   function automatic logic [7:0] rom_fn(input logic [11:0] a);
      logic [11:0] t;
      t = (a * 12'd37) ^ (a >> 4) ^ 12'h05A;
      return t[7:0];
   endfunction

   assign rom_data = rom_fn(rom_addr);

   lcd_show_char dut (
      .sys_clk        (sys_clk),
      .sys_rst_n      (sys_rst_n),
      .show_char_flag (show_char_flag),
      .ascii_num      (ascii_num),
      .start_x        (start_x),
      .start_y        (start_y),
      .en_size        (en_size),
      .show_char_done (show_char_done),
      .busy           (busy),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .wr_req         (wr_req),
      .wr_data        (wr_data),
      .wr_done        (wr_done)
   );

   // byte writer: logs each request, answers after a latency and
   // counts handshake violations seen while the byte is pending
   initial begin
      logic [8:0] held;
      int lat;
      bit ab;
      forever begin
         @(posedge sys_clk); #1;
         if (wr_req === 1'b1 && sys_rst_n === 1'b1) begin
            held = wr_data;
            got.push_back(held);
            wr_cnt++;
            lat = rand_lat ? int'($urandom_range(1, 20)) : 2;
            ab = 1'b0;
            for (int k = 0; k < lat; k++) begin
               @(posedge sys_clk); #1;
               if (sys_rst_n !== 1'b1) ab = 1'b1;
               if (!ab && (wr_req !== 1'b0 || wr_data !== held))
                  hs_viol++;
            end
            if (!ab) begin
               wr_done_w = 1'b1;
               @(posedge sys_clk); #1;
               wr_done_w = 1'b0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge sys_clk);
         if (show_char_done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
         end
         if (busy === 1'b1 && !prev_busy) begin
            rise_cnt++;
            last_rise_cyc = cyc;
         end
         prev_busy = (busy === 1'b1);
         if (wr_req === 1'b1 && wr_data[8] && got.size() >= 12) begin
            if (int'(rom_addr) < rmin) rmin = int'(rom_addr);
            if (int'(rom_addr) > rmax) rmax = int'(rom_addr);
         end
      end
   end

   function automatic void build_exp(input logic [6:0] a,
                                     input logic [8:0] x,
                                     input logic [8:0] y,
                                     input logic sz);
      int w, h;
      logic [6:0] g;
      logic [8:0] xe, ye;
      logic [11:0] bse, ad;
      logic [7:0] b;
      logic [15:0] col;
      w = sz ? 8 : 6;
      h = sz ? 16 : 12;
      g = (a > 7'd94) ? 7'd0 : a;
      xe = x + 9'(w - 1);
      ye = y + 9'(h - 1);
      bse = sz ? 12'd0 : 12'd1520;
      exp_q.push_back(9'h02A);
      exp_q.push_back({1'b1, 7'b0, x[8]});
      exp_q.push_back({1'b1, x[7:0]});
      exp_q.push_back({1'b1, 7'b0, xe[8]});
      exp_q.push_back({1'b1, xe[7:0]});
      exp_q.push_back(9'h02B);
      exp_q.push_back({1'b1, 7'b0, y[8]});
      exp_q.push_back({1'b1, y[7:0]});
      exp_q.push_back({1'b1, 7'b0, ye[8]});
      exp_q.push_back({1'b1, ye[7:0]});
      exp_q.push_back(9'h02C);
      for (int r = 0; r < h; r++) begin
         ad = bse + 12'(g) * 12'(h) + 12'(r);
         b = rom_fn(ad);
         for (int c = 0; c < w; c++) begin
            col = b[7 - c] ? 16'h0000 : 16'hFFFF;
            exp_q.push_back({1'b1, col[15:8]});
            exp_q.push_back({1'b1, col[7:0]});
         end
      end
   endfunction

   function automatic int n_diff();
      int n;
      n = 0;
      for (int i = 0; i < got.size(); i++)
         if (i >= exp_q.size() || got[i] !== exp_q[i]) n++;
      if (exp_q.size() > got.size()) n += exp_q.size() - got.size();
      return n;
   endfunction

   task automatic clear_logs();
      got.delete();
      exp_q.delete();
      wr_cnt = 0;
      rmin = 4095;
      rmax = 0;
   endtask

   task automatic req(input logic [6:0] a, input logic [8:0] x,
                      input logic [8:0] y, input logic sz);
      @(negedge sys_clk);
      ascii_num = a;
      start_x = x;
      start_y = y;
      en_size = sz;
      show_char_flag = 1'b1;
      @(negedge sys_clk);
      show_char_flag = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit to);
      int d0;
      d0 = done_cnt;
      to = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge sys_clk);
         if (done_cnt != d0) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      show_char_flag = 1'b0;
      ascii_num = '0;
      start_x = '0;
      start_y = '0;
      en_size = 1'b0;
      repeat (3) @(negedge sys_clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got=%b want=0", busy);
      end
      checks++;
      if (show_char_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_done got=%b want=0", show_char_done);
      end
      checks++;
      if (wr_req !== 1'b0 || wr_data !== 9'h000) begin
         failures++;
         $display("FAIL reset_wr got=%b/%h want=0/000", wr_req, wr_data);
      end
      checks++;
      if (rom_addr !== 12'd0) begin
         failures++;
         $display("FAIL reset_rom_addr got=%0d want=0", rom_addr);
      end
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);
   endtask

   task automatic test_basic_8x16();
      logic [8:0] hand[11];
      bit to;
      int d0, bad;
      hand = '{9'h02A, 9'h100, 9'h148, 9'h100, 9'h14F, 9'h02B,
               9'h100, 9'h110, 9'h100, 9'h11F, 9'h02C};
      clear_logs();
      build_exp(7'd82, 9'd72, 9'd16, 1'b1);
      d0 = done_cnt;
      req(7'd82, 9'd72, 9'd16, 1'b1);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL basic_busy_rise got=%b want=1", busy);
      end
      wait_done(20000, to);
      checks++;
      if (to) begin
         failures++;
         $display("FAIL basic_timeout got=no_done want=done");
      end
      repeat (3) @(negedge sys_clk);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL basic_busy_hold got=%b want=1", busy);
      end
      @(negedge sys_clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_busy_fall got=%b want=0", busy);
      end
      bad = 0;
      for (int i = 0; i < 11; i++)
         if (i >= got.size() || got[i] !== hand[i]) bad++;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL basic_cmd_bytes got=%0d_wrong want=0_wrong", bad);
      end
      checks++;
      if (wr_cnt != 267) begin
         failures++;
         $display("FAIL basic_count got=%0d want=267", wr_cnt);
      end
      checks++;
      if (n_diff() != 0) begin
         failures++;
         $display("FAIL basic_stream got=%0d_diffs want=0", n_diff());
      end
      checks++;
      if (rmin != 1312 || rmax != 1327) begin
         failures++;
         $display("FAIL basic_rom got=%0d..%0d want=1312..1327", rmin, rmax);
      end
      repeat (10) @(negedge sys_clk);
      checks++;
      if (done_cnt - d0 != 1) begin
         failures++;
         $display("FAIL basic_done_pulses got=%0d want=1", done_cnt - d0);
      end
   endtask

   task automatic test_6x12();
      bit to;
      clear_logs();
      build_exp(7'd26, 9'd300, 9'd48, 1'b0);
      req(7'd26, 9'd300, 9'd48, 1'b0);
      wait_done(20000, to);
      checks++;
      if (to) begin
         failures++;
         $display("FAIL s12_timeout got=no_done want=done");
      end
      repeat (6) @(negedge sys_clk);
      checks++;
      if (got.size() < 10 ||
          {got[1], got[2], got[3], got[4]} !==
          {9'h101, 9'h12C, 9'h101, 9'h131} ||
          {got[6], got[7], got[8], got[9]} !==
          {9'h100, 9'h130, 9'h100, 9'h13B}) begin
         failures++;
         $display("FAIL s12_window got=size%0d want=101,12C,101,131,100,130,100,13B",
                  got.size());
      end
      checks++;
      if (wr_cnt != 155) begin
         failures++;
         $display("FAIL s12_count got=%0d want=155", wr_cnt);
      end
      checks++;
      if (n_diff() != 0) begin
         failures++;
         $display("FAIL s12_stream got=%0d_diffs want=0", n_diff());
      end
      checks++;
      if (rmin != 1832 || rmax != 1843) begin
         failures++;
         $display("FAIL s12_rom got=%0d..%0d want=1832..1843", rmin, rmax);
      end
   endtask

   task automatic test_flag_spam();
      int d0, r0, first_done, i;
      bit seen_first;
      clear_logs();
      build_exp(7'd33, 9'd5, 9'd7, 1'b1);
      build_exp(7'd40, 9'd100, 9'd200, 1'b0);
      d0 = done_cnt;
      r0 = rise_cnt;
      seen_first = 1'b0;
      first_done = 0;
      for (i = 0; i < 30000; i++) begin
         @(negedge sys_clk);
         if (!seen_first && done_cnt - d0 >= 1) begin
            seen_first = 1'b1;
            first_done = last_done_cyc;
         end
         if (done_cnt - d0 >= 2) break;
         if (rise_cnt - r0 < 2) begin
            show_char_flag = (i % 3 == 0);
            if (i == 0) begin
               ascii_num = 7'd33; start_x = 9'd5;
               start_y = 9'd7; en_size = 1'b1;
            end else begin
               ascii_num = 7'd40; start_x = 9'd100;
               start_y = 9'd200; en_size = 1'b0;
            end
         end else begin
            show_char_flag = 1'b0;
         end
      end
      show_char_flag = 1'b0;
      checks++;
      if (done_cnt - d0 != 2) begin
         failures++;
         $display("FAIL spam_done got=%0d want=2", done_cnt - d0);
      end
      checks++;
      if (rise_cnt - r0 != 2) begin
         failures++;
         $display("FAIL spam_accepts got=%0d want=2", rise_cnt - r0);
      end
      checks++;
      if (last_rise_cyc - first_done < 5) begin
         failures++;
         $display("FAIL spam_holdoff got=%0d want>=5",
                  last_rise_cyc - first_done);
      end
      checks++;
      if (n_diff() != 0) begin
         failures++;
         $display("FAIL spam_stream got=%0d_diffs want=0", n_diff());
      end
      repeat (8) @(negedge sys_clk);
   endtask

   task automatic test_random_latency();
      bit to;
      int v0;
      clear_logs();
      v0 = hs_viol;
      rand_lat = 1'b1;
      build_exp(7'd82, 9'd72, 9'd16, 1'b1);
      req(7'd82, 9'd72, 9'd16, 1'b1);
      wait_done(40000, to);
      checks++;
      if (to) begin
         failures++;
         $display("FAIL rand_timeout got=no_done want=done");
      end
      repeat (6) @(negedge sys_clk);
      rand_lat = 1'b0;
      checks++;
      if (n_diff() != 0 || wr_cnt != 267) begin
         failures++;
         $display("FAIL rand_stream got=%0d_diffs/%0d want=0/267",
                  n_diff(), wr_cnt);
      end
      checks++;
      if (hs_viol != v0) begin
         failures++;
         $display("FAIL rand_handshake got=%0d want=0", hs_viol - v0);
      end
   endtask

   task automatic test_reset_mid();
      bit to;
      int d0;
      clear_logs();
      req(7'd82, 9'd72, 9'd16, 1'b1);
      to = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         @(negedge sys_clk);
         if (wr_cnt >= 100) begin
            to = 1'b0;
            break;
         end
      end
      checks++;
      if (to) begin
         failures++;
         $display("FAIL rstmid_reach got=%0d want=100", wr_cnt);
      end
      d0 = done_cnt;
      sys_rst_n = 1'b0;
      #1;
      checks++;
      if ({show_char_done, busy, wr_req, wr_data, rom_addr} !== 24'd0) begin
         failures++;
         $display("FAIL rstmid_outputs got=%b%b%b/%h/%0d want=000/000/0",
                  show_char_done, busy, wr_req, wr_data, rom_addr);
      end
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (30) @(negedge sys_clk);
      checks++;
      if (done_cnt != d0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_no_done got=%0d/%b want=0/0",
                  done_cnt - d0, busy);
      end
      clear_logs();
      build_exp(7'd82, 9'd72, 9'd16, 1'b1);
      req(7'd82, 9'd72, 9'd16, 1'b1);
      wait_done(20000, to);
      repeat (6) @(negedge sys_clk);
      checks++;
      if (to || wr_cnt != 267 || n_diff() != 0) begin
         failures++;
         $display("FAIL rstmid_fresh got=%0d_writes/%0d_diffs want=267/0",
                  wr_cnt, n_diff());
      end
   endtask

   task automatic test_out_of_range();
      bit to;
      repeat (2) begin
         @(negedge sys_clk);
         wr_done_s = 1'b1;
         @(negedge sys_clk);
         wr_done_s = 1'b0;
      end
      clear_logs();
      build_exp(7'd100, 9'd0, 9'd0, 1'b1);
      req(7'd100, 9'd0, 9'd0, 1'b1);
      wait_done(20000, to);
      repeat (6) @(negedge sys_clk);
      checks++;
      if (to || wr_cnt != 267 || n_diff() != 0) begin
         failures++;
         $display("FAIL oob_stream got=%0d_writes/%0d_diffs want=267/0",
                  wr_cnt, n_diff());
      end
      checks++;
      if (rmin != 0 || rmax != 15) begin
         failures++;
         $display("FAIL oob_rom got=%0d..%0d want=0..15", rmin, rmax);
      end
      checks++;
      if (hs_viol != 0) begin
         failures++;
         $display("FAIL handshake_total got=%0d want=0", hs_viol);
      end
   endtask

   initial begin
      test_reset();
      test_basic_8x16();
      test_6x12();
      test_flag_spam();
      test_random_latency();
      test_reset_mid();
      test_out_of_range();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
